// File: rtl/ipsxe_floating_point_exp_arb_v1_0.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ipsxe_floating_point_exp_arb_v1_0: round-robin share of one exp core.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ipsxe_floating_point_exp_arb_v1_0 #(
  parameter int NUM_CH           = 4,
  parameter int FLOAT_EXP_WIDTH  = 8,
  parameter int FLOAT_FRAC_WIDTH = 24,
  parameter int TAG_DEPTH        = 16,
  localparam int FW    = FLOAT_EXP_WIDTH + FLOAT_FRAC_WIDTH,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W = $clog2(TAG_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_aclken,
  input  logic [NUM_CH-1:0]    i_req_valid,
  input  logic [NUM_CH*FW-1:0] i_req_data,
  output logic [NUM_CH-1:0]    o_req_ready,
  output logic [FW-1:0]        o_core_data,
  output logic                 o_core_valid,
  input  logic [FW-1:0]        i_core_result,
  input  logic                 i_core_overflow,
  input  logic                 i_core_underflow,
  input  logic                 i_core_valid,
  output logic [NUM_CH-1:0]    o_rsp_valid,
  output logic [FW-1:0]        o_rsp_data,
  output logic                 o_rsp_overflow,
  output logic                 o_rsp_underflow,
  output logic [CH_W-1:0]      o_rsp_ch,
  output logic [CNT_W-1:0]     o_inflight,
  output logic                 o_err_orphan
);

  logic [CH_W-1:0]  rr_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CH_W-1:0]  tag_mem [TAG_DEPTH];

  logic             grant_any;
  logic [CH_W-1:0]  grant_idx;
  logic [CH_W-1:0]  scan_idx;
  logic             eligible;
  logic             issue;
  logic             pop;
  logic             orphan;
  logic [CH_W-1:0]  pop_tag;
  logic [FW-1:0]    sel_data;

  // First valid channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!grant_any && i_req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Eligibility looks only at the registered count, so a full FIFO refuses
  // a push even when a pop happens on the same edge.
  assign eligible = i_aclken && (count < CNT_W'(TAG_DEPTH));
  assign issue    = eligible && grant_any;
  assign pop      = i_core_valid && (count != '0);
  assign orphan   = i_core_valid && (count == '0);
  assign pop_tag  = tag_mem[rd_ptr];
  assign sel_data = i_req_data[grant_idx*FW +: FW];

  always_comb begin
    o_req_ready = '0;
    if (issue) begin
      o_req_ready = NUM_CH'(1) << grant_idx;
    end
  end

  assign o_inflight = count;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_aclken && issue) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      o_core_valid    <= 1'b0;
      o_core_data     <= '0;
      o_rsp_valid     <= '0;
      o_rsp_data      <= '0;
      o_rsp_overflow  <= 1'b0;
      o_rsp_underflow <= 1'b0;
      o_rsp_ch        <= '0;
      o_err_orphan    <= 1'b0;
    end else if (i_aclken) begin
      o_core_valid <= issue;
      if (issue) begin
        o_core_data <= sel_data;
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        o_rsp_valid     <= NUM_CH'(1) << pop_tag;
        o_rsp_ch        <= pop_tag;
        o_rsp_data      <= i_core_result;
        o_rsp_overflow  <= i_core_overflow;
        o_rsp_underflow <= i_core_underflow;
      end else begin
        o_rsp_valid <= '0;
      end
      if (orphan) begin
        o_err_orphan <= 1'b1;
      end
      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ipsxe_floating_point_exp_arb_v1_0.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ipsxe_floating_point_exp_arb_v1_0: randomized bench with stub exp core|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ipsxe_floating_point_exp_arb_v1_0;

  localparam int NUM_CH    = 4;
  localparam int FW        = 32;
  localparam int TAG_DEPTH = 8;
  localparam int CORE_L    = 5;
  localparam int CH_W      = 2;
  localparam int CNT_W     = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 aclken = 1'b1;
  logic [NUM_CH-1:0]    req_valid = '0;
  logic [NUM_CH*FW-1:0] req_data = '0;
  logic [NUM_CH-1:0]    req_ready;
  logic [FW-1:0]        core_data;
  logic                 core_valid_out;
  logic [FW-1:0]        core_result = '0;
  logic                 core_ov = 1'b0;
  logic                 core_un = 1'b0;
  logic                 core_valid = 1'b0;
  logic [NUM_CH-1:0]    rsp_valid;
  logic [FW-1:0]        rsp_data;
  logic                 rsp_ov;
  logic                 rsp_un;
  logic [CH_W-1:0]      rsp_ch;
  logic [CNT_W-1:0]     inflight;
  logic                 err_orphan;

  always #5 clk = ~clk;

  ipsxe_floating_point_exp_arb_v1_0 #(
    .NUM_CH(NUM_CH), .FLOAT_EXP_WIDTH(8), .FLOAT_FRAC_WIDTH(24), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_aclken(aclken),
    .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
    .o_core_data(core_data), .o_core_valid(core_valid_out),
    .i_core_result(core_result), .i_core_overflow(core_ov),
    .i_core_underflow(core_un), .i_core_valid(core_valid),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_overflow(rsp_ov),
    .o_rsp_underflow(rsp_un), .o_rsp_ch(rsp_ch), .o_inflight(inflight),
    .o_err_orphan(err_orphan)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stub exp core: exact for z = 0, crude range rule (|z| >= 64) for the flags,
  // and a reversible scramble otherwise so every result is traceable.
  function automatic logic [FW+1:0] core_fn(input logic [FW-1:0] z);
    logic big;
    big = (z[30:23] >= 8'd133);
    if (z == '0)        return {2'b00, 32'h3F80_0000};
    else if (big && !z[31]) return {2'b10, 32'h7F80_0000};
    else if (big)       return {2'b01, 32'h0000_0000};
    else                return {2'b00, z ^ 32'h5A5A_0F0F};
  endfunction

  // Core model: results leave CORE_L enabled cycles after the operand is sampled.
  logic          hold = 1'b0;
  logic          inject = 1'b0;
  int            ecyc = 0;
  logic [FW-1:0] cq_data[$];
  int            cq_due[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      cq_data.delete();
      cq_due.delete();
      core_valid <= 1'b0;
    end else if (inject) begin
      core_valid  <= 1'b1;
      core_result <= 32'hDEAD_BEEF;
    end else if (aclken) begin
      ecyc       <= ecyc + 1;
      core_valid <= 1'b0;
      if (!hold && cq_due.size() > 0 && cq_due[0] <= ecyc) begin
        {core_ov, core_un, core_result} <= core_fn(cq_data[0]);
        core_valid <= 1'b1;
        void'(cq_data.pop_front());
        void'(cq_due.pop_front());
      end
      if (core_valid_out) begin
        cq_data.push_back(core_data);
        cq_due.push_back(ecyc + CORE_L);
      end
    end
  end

  // Requesters and reference model state.
  logic [FW-1:0]     chq [NUM_CH][$];
  int                m_ptr = 0;
  int                m_count = 0;
  int                sb_ch[$];
  logic [FW+1:0]     sb_res[$];
  logic              exp_cv = 1'b0;
  logic [FW-1:0]     exp_cd = '0;
  logic [NUM_CH-1:0] exp_rv = '0;
  logic [FW-1:0]     exp_rdata = '0;
  logic              exp_rov = 1'b0;
  logic              exp_run = 1'b0;
  logic [CH_W-1:0]   exp_rch = '0;
  logic              exp_orphan = 1'b0;
  int                cyc = 0;
  int                last_acc_cyc = 0;
  int                last_rsp_cyc = 0;
  logic [35:0]       res_log[$];
  logic [35:0]       log_a[$];
  int                hits[NUM_CH];

  task automatic drive_reqs();
    for (int c = 0; c < NUM_CH; c++) begin
      req_valid[c]          = (chq[c].size() > 0);
      req_data[c*FW +: FW]  = (chq[c].size() > 0) ? chq[c][0] : '0;
    end
  endtask

  task automatic step();
    logic [NUM_CH-1:0] exp_ready;
    int                gk;
    int                k;
    logic              pop_now;
    logic              orphan_now;
    @(negedge clk);
    exp_ready = '0;
    gk = -1;
    if (aclken && m_count < TAG_DEPTH) begin
      for (int i = 0; i < NUM_CH; i++) begin
        k = (m_ptr + i) % NUM_CH;
        if (gk < 0 && chq[k].size() > 0) gk = k;
      end
      if (gk >= 0) exp_ready[gk] = 1'b1;
    end
    check("ready", 64'(req_ready), 64'(exp_ready));
    check("inflight", 64'(inflight), 64'(m_count));
    check("core_valid", 64'(core_valid_out), 64'(exp_cv));
    check("core_data", 64'(core_data), 64'(exp_cd));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check("rsp_fields", {27'd0, rsp_ch, rsp_ov, rsp_un, rsp_data},
          {27'd0, exp_rch, exp_rov, exp_run, exp_rdata});
    check("orphan", 64'(err_orphan), 64'(exp_orphan));
    if (aclken && rsp_valid != '0) begin
      res_log.push_back({rsp_ch, rsp_ov, rsp_un, rsp_data});
      hits[rsp_ch]++;
      last_rsp_cyc = cyc;
    end
    pop_now    = aclken && core_valid && (m_count > 0) && (sb_ch.size() > 0);
    orphan_now = aclken && core_valid && (m_count == 0);
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_ptr = 0; m_count = 0; sb_ch.delete(); sb_res.delete();
      exp_cv = 0; exp_cd = '0; exp_rv = '0; exp_rdata = '0;
      exp_rov = 0; exp_run = 0; exp_rch = '0; exp_orphan = 0;
    end else if (aclken) begin
      exp_cv = (gk >= 0);
      if (gk >= 0) begin
        exp_cd = chq[gk][0];
        sb_ch.push_back(gk);
        sb_res.push_back(core_fn(chq[gk][0]));
        void'(chq[gk].pop_front());
        m_ptr = (gk + 1) % NUM_CH;
        m_count++;
        last_acc_cyc = cyc;
      end
      if (pop_now) begin
        exp_rv  = NUM_CH'(1) << sb_ch[0];
        exp_rch = CH_W'(sb_ch[0]);
        {exp_rov, exp_run, exp_rdata} = sb_res[0];
        void'(sb_ch.pop_front());
        void'(sb_res.pop_front());
        m_count--;
      end else begin
        exp_rv = '0;
      end
      if (orphan_now) exp_orphan = 1'b1;
    end
    #1;
    drive_reqs();
  endtask

  function automatic bit busy();
    bit b;
    b = (m_count > 0) || (exp_rv != '0);
    for (int c = 0; c < NUM_CH; c++) if (chq[c].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input bit gate);
    int n;
    n = 0;
    while (busy() && n < 400) begin
      step();
      aclken = gate ? ~aclken : 1'b1;
      n++;
    end
    aclken = 1'b1;
    if (busy()) check("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [FW-1:0] ops_d[12];
  int            ops_c[12];

  initial begin
    drive_reqs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single channel, z = 0, latency from accept to response.
    res_log.delete();
    chq[2].push_back(32'h0000_0000);
    drive_reqs();
    for (int n = 0; n < 40 && res_log.size() == 0; n++) step();
    check("single_count", 64'(res_log.size()), 64'd1);
    if (res_log.size() > 0) check("single_rsp", 64'(res_log[0]), {28'd0, 2'd2, 2'b00, 32'h3F80_0000});
    check("single_latency", 64'(last_rsp_cyc - last_acc_cyc), 64'(CORE_L + 2));
    drain(1'b0);

    // All channels continuously valid: round-robin fairness.
    for (int c = 0; c < NUM_CH; c++) hits[c] = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NUM_CH; c++) chq[c].push_back($urandom);
    drive_reqs();
    drain(1'b0);
    for (int c = 0; c < NUM_CH; c++) check("fair_hits", 64'(hits[c]), 64'd4);

    // Full FIFO with the core stalled.
    hold = 1'b1;
    for (int i = 0; i < 10; i++) chq[i % NUM_CH].push_back($urandom);
    drive_reqs();
    repeat (20) step();
    check("full_inflight", 64'(inflight), 64'(TAG_DEPTH));
    check("full_ready", 64'(req_ready), 64'd0);
    check("full_left", 64'(chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size()), 64'd2);
    for (int r = 0; r < 2; r++) begin
      hold = 1'b0;
      step();
      hold = 1'b1;
      step();
      step();
      check("refill_inflight", 64'(inflight), 64'(TAG_DEPTH));
    end
    hold = 1'b0;
    drain(1'b0);

    // Same stream ungated and with aclken toggling.
    for (int i = 0; i < 12; i++) begin
      ops_c[i] = $urandom_range(0, NUM_CH - 1);
      ops_d[i] = $urandom;
    end
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      res_log.delete();
      for (int i = 0; i < 12; i++) chq[ops_c[i]].push_back(ops_d[i]);
      drive_reqs();
      drain(pass == 1);
      if (pass == 0) log_a = res_log;
    end
    check("gate_len", 64'(res_log.size()), 64'(log_a.size()));
    for (int i = 0; i < 12 && i < res_log.size() && i < log_a.size(); i++)
      check("gate_seq", 64'(res_log[i]), 64'(log_a[i]));

    // Overflow / underflow flags stay with their own channel.
    do_reset();
    res_log.delete();
    chq[1].push_back(32'h42C8_0000);
    chq[3].push_back(32'hC2C8_0000);
    drive_reqs();
    drain(1'b0);
    check("flag_count", 64'(res_log.size()), 64'd2);
    if (res_log.size() > 1) begin
      check("flag_ovf", 64'(res_log[0]), {28'd0, 2'd1, 2'b10, 32'h7F80_0000});
      check("flag_unf", 64'(res_log[1]), {28'd0, 2'd3, 2'b01, 32'h0000_0000});
    end

    // Reset mid-stream, then a stale core result.
    for (int i = 0; i < 3; i++) chq[0].push_back($urandom);
    drive_reqs();
    repeat (4) step();
    check("pre_rst_inflight", 64'(inflight), 64'd3);
    do_reset();
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_outputs", {rsp_valid, core_valid_out, err_orphan, rsp_ov, rsp_un, rsp_ch},
          64'd0);
    check("rst_data", {core_data, rsp_data}, 64'd0);
    res_log.delete();
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (3) step();
    check("orphan_set", 64'(err_orphan), 64'd1);
    check("orphan_no_rsp", 64'(res_log.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
